// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 16-bit ALU between two requesters.
// Optional per-requester accept counters are enabled by defining ALU_PERF_CNT_EN.
module alu_arbiter #(
    parameter int WIDTH = 16
`ifdef ALU_PERF_CNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_PERF_CNT_EN
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_cnt0,
    output logic [CNT_W-1:0] perf_cnt1,
`endif
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [4:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [4:0]       rsp1_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    input  logic             alu_set,
    input  logic             alu_zero
);

    // state | meaning
    // IDLE  | no op in flight; grant and accept one command
    // ISSUE | ALU settles from registered operands; result sampled at end of cycle
    // RESP  | owner's response valid; held until the owner takes it
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'b011;

    state_t state, state_next;

    logic             owner;
    logic             last;
    logic             grant;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             illegal;
    logic [4:0]       alu_flags;

    // Both valid: give the turn to whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign sel_op    = grant ? req1_op : req0_op;
    assign sel_a     = grant ? req1_a  : req0_a;
    assign sel_b     = grant ? req1_b  : req0_b;
    assign illegal   = (alu_op == OP_ILLEGAL);
    assign alu_flags = {1'b0, alu_overflow, alu_cout, alu_set, alu_zero};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers only move on accept, so the ALU inputs are quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (accept) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            owner  <= grant;
            last   <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_result <= '0;
            rsp0_flags  <= '0;
            rsp1_result <= '0;
            rsp1_flags  <= '0;
        end else if (state == ISSUE) begin
            if (!owner) begin
                rsp0_result <= illegal ? '0 : alu_result;
                rsp0_flags  <= illegal ? 5'b10000 : alu_flags;
            end else begin
                rsp1_result <= illegal ? '0 : alu_result;
                rsp1_flags  <= illegal ? 5'b10000 : alu_flags;
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters saturate; a clear in the same cycle as an accept wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else if (perf_clr) begin
            perf_cnt0 <= '0;
            perf_cnt1 <= '0;
        end else if (accept) begin
            if (!grant && (perf_cnt0 != '1)) begin
                perf_cnt0 <= perf_cnt0 + CNT_ONE;
            end
            if (grant && (perf_cnt1 != '1)) begin
                perf_cnt1 <= perf_cnt1 + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 16-bit ripple ALU attached.
// Perf counter checks are compiled in when ALU_PERF_CNT_EN is defined.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp0_result, rsp1_result;
    logic [4:0]  rsp0_flags, rsp1_flags;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_cout, alu_overflow, alu_set, alu_zero;
`ifdef ALU_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] perf_cnt0, perf_cnt1;
`endif

    typedef struct packed {
        logic [15:0] r;
        logic [4:0]  f;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ord_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ALU_PERF_CNT_EN
        .perf_clr(perf_clr),
        .perf_cnt0(perf_cnt0),
        .perf_cnt1(perf_cnt1),
`endif
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow), .alu_set(alu_set), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple ALU: op[2] inverts b and supplies carry-in; op[1:0] picks AND/OR/ADD/SLT.
    logic [15:0] bb;
    logic [16:0] sum;
    always_comb begin
        bb           = alu_op[2] ? ~alu_b : alu_b;
        sum          = {1'b0, alu_a} + {1'b0, bb} + {16'h0, alu_op[2]};
        alu_cout     = sum[16];
        alu_overflow = (alu_a[15] == bb[15]) && (sum[15] != alu_a[15]);
        alu_set      = sum[15] ^ alu_overflow;
        case (alu_op[1:0])
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = sum[15:0];
            default: alu_result = {15'h0, alu_set};
        endcase
        alu_zero = (alu_result == 16'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic flag_fail(input string name);
        total_cnt++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    task automatic drive(input int n, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er,
                         input logic [4:0] ef, input bit push);
        bit done;
        exp_t e;
        done = 0;
        e.r = er;
        e.f = ef;
        if (push) begin
            if (n == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (n == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) done = 1;
        end
        if (!done) flag_fail("accept timeout");
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q0.size() + q1.size() + ord_q.size()) != 0; i++)
            @(posedge clk);
        if ((q0.size() + q1.size() + ord_q.size()) != 0) flag_fail("drain timeout");
        #1;
    endtask

    int          who;
    logic [15:0] got_r;
    logic [4:0]  got_f;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) flag_fail("both rsp valid");
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                who   = (rsp1_valid && rsp1_ready) ? 1 : 0;
                got_r = (who == 1) ? rsp1_result : rsp0_result;
                got_f = (who == 1) ? rsp1_flags : rsp0_flags;
                if ((who == 1) ? (q1.size() == 0) : (q0.size() == 0)) begin
                    flag_fail("unexpected rsp");
                end else begin
                    mon_e = (who == 1) ? q1.pop_front() : q0.pop_front();
                    check("rsp result", 32'(got_r), 32'(mon_e.r));
                    check("rsp flags", 32'(got_f), 32'(mon_e.f));
                end
                if (ord_q.size() == 0) flag_fail("rsp with no expected owner");
                else check("grant order", 32'(who), 32'(ord_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1; rsp1_ready = 1;
`ifdef ALU_PERF_CNT_EN
        perf_clr = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("reset rsp1_valid", 32'(rsp1_valid), 32'h0);
        check("reset req0_ready", 32'(req0_ready), 32'h0);
        check("reset req1_ready", 32'(req1_ready), 32'h0);
        check("reset alu_a", 32'(alu_a), 32'h0);
        check("reset alu_b", 32'(alu_b), 32'h0);
        check("reset alu_op", 32'(alu_op), 32'h0);
        check("reset rsp0_result", 32'(rsp0_result), 32'h0);
        check("reset rsp1_flags", 32'(rsp1_flags), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters held valid: grants alternate starting with req0.
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        fork
            begin
                drive(0, 3'b000, 16'hFF0F, 16'hFFFF, 16'hFF0F, 5'b00110, 1);
                drive(0, 3'b000, 16'h00FF, 16'h0F0F, 16'h000F, 5'b00000, 1);
            end
            begin
                drive(1, 3'b001, 16'hF0F0, 16'h0F0F, 16'hFFFF, 5'b00010, 1);
                drive(1, 3'b001, 16'h1200, 16'h0034, 16'h1234, 5'b00000, 1);
            end
        join
        drain();

        // ADD overflow and two-edge latency from the accept handshake.
        @(posedge clk);
        #1;
        ord_q.push_back(0);
        drive(0, 3'b010, 16'h7FFF, 16'h7FFF, 16'hFFFE, 5'b01000, 1);
        check("latency issue rsp0_valid", 32'(rsp0_valid), 32'h0);
        @(posedge clk);
        #1;
        check("latency resp rsp0_valid", 32'(rsp0_valid), 32'h1);
        check("latency resp rsp0_result", 32'(rsp0_result), 32'hFFFE);
        drain();

        // req1 alone, back-to-back: SUB to zero then SLT.
        ord_q.push_back(1); ord_q.push_back(1);
        drive(1, 3'b110, 16'hBEEF, 16'hBEEF, 16'h0000, 5'b00101, 1);
        drive(1, 3'b111, 16'h8000, 16'h0001, 16'h0001, 5'b01110, 1);
        drain();

        // Response back-pressure while req1 waits.
        rsp0_ready = 1'b0;
        ord_q.push_back(0); ord_q.push_back(1);
        drive(0, 3'b010, 16'h1234, 16'h1111, 16'h2345, 5'b00000, 1);
        fork
            drive(1, 3'b001, 16'h1200, 16'h0034, 16'h1234, 5'b00000, 1);
        join_none
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall rsp0_valid", 32'(rsp0_valid), 32'h1);
            check("stall rsp0_result", 32'(rsp0_result), 32'h2345);
            check("stall rsp0_flags", 32'(rsp0_flags), 32'h0);
            check("stall req0_ready", 32'(req0_ready), 32'h0);
            check("stall req1_ready", 32'(req1_ready), 32'h0);
            check("stall alu_a", 32'(alu_a), 32'h1234);
            check("stall alu_b", 32'(alu_b), 32'h1111);
            check("stall alu_op", 32'(alu_op), 32'h2);
        end
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("release idle req1_ready", 32'(req1_ready), 32'h1);
        wait fork;
        drain();

        // Illegal op 011 answers with err only.
        ord_q.push_back(0);
        drive(0, 3'b011, 16'h1234, 16'h5678, 16'h0000, 5'b10000, 1);
        drain();

        // Reset while the op is in ISSUE: nothing comes back, pointer restored.
        drive(0, 3'b010, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 0);
        rst_n = 1'b0;
        #1;
        check("rst rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("rst rsp0_result", 32'(rsp0_result), 32'h0);
        check("rst rsp0_flags", 32'(rsp0_flags), 32'h0);
        check("rst alu_a", 32'(alu_a), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-rst rsp0_valid", 32'(rsp0_valid), 32'h0);
            check("post-rst rsp1_valid", 32'(rsp1_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("post-rst grant req0_ready", 32'(req0_ready), 32'h1);
        check("post-rst grant req1_ready", 32'(req1_ready), 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef ALU_PERF_CNT_EN
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            ord_q.push_back(0);
            drive(0, 3'b001, 16'h0F00, 16'h00F0, 16'h0FF0, 5'b00000, 1);
        end
        for (int i = 0; i < 2; i++) begin
            ord_q.push_back(1);
            drive(1, 3'b000, 16'h0F00, 16'h0FF0, 16'h0F00, 5'b00000, 1);
        end
        drain();
        check("perf_cnt0", 32'(perf_cnt0), 32'd3);
        check("perf_cnt1", 32'(perf_cnt1), 32'd2);
        @(posedge clk);
        #1;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check("perf_cnt0 cleared", 32'(perf_cnt0), 32'd0);
        check("perf_cnt1 cleared", 32'(perf_cnt1), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
